psx_irq_ctrl: RTL and testbench
===============================

PSX_IRQ_CTRL -- requirements
Module: psx_irq_ctrl

Interface
REQ-001 SHALL provide parameter NUM_SRC, default 11: number of interrupt sources, legal range 1..16.
REQ-002 SHALL provide parameter LEVEL_MASK [15:0], default 16'h0000: bit n=1 makes source n level-sensitive; bit n=0 makes it edge-sensitive.
REQ-003 SHALL provide port sys_clk  input  1: sole clock; all state on rising edge.
REQ-004 SHALL provide port rst  input  1: asynchronous, active-high reset.
REQ-005 SHALL provide port irq_i  input  NUM_SRC: source request lines, synchronous to sys_clk; bit 0 = vblank, bit 10 = lightpen at default.
REQ-006 SHALL provide port wen  input  1: register write strobe, single cycle.
REQ-007 SHALL provide port ben  input  2: byte enables; ben[0] covers data_i[7:0], ben[1] covers data_i[15:8].
REQ-008 SHALL provide port addr  input  2: register select; 0=STAT, 1=MASK, 2=FORCE, 3=reserved (writes ignored).
REQ-009 SHALL provide port data_i  input  16: write data.
REQ-010 SHALL provide port stat_o  output  32: status, zero-extended above NUM_SRC.
REQ-011 SHALL provide port mask_o  output  32: mask, zero-extended above NUM_SRC.
REQ-012 SHALL provide port irq_o  output  1: registered CPU interrupt request.
REQ-013 SHALL provide port vec_o  output  4: index of highest-priority pending source.
REQ-014 SHALL provide port vec_valid_o  output  1: vec_o is meaningful.

Function
REQ-015 SHALL register each irq_i bit into prev[n] every cycle; edge[n] = irq_i[n] & ~prev[n].
REQ-016 Edge source n SHALL set stat[n] on the cycle after edge[n]; a level held high sets it once only.
REQ-017 Level source n SHALL set stat[n] on every cycle irq_i[n] is high.
REQ-018 A STAT write SHALL AND stat with data_i in enabled byte lanes only (write-0-to-clear; write-1 has no effect).
REQ-019 SHALL give set priority when a set and a clear hit the same bit in the same cycle: stat[n]=1, the event is not lost.
REQ-020 A clear of a level source while irq_i[n] is high SHALL leave stat[n]=1.
REQ-021 A MASK write SHALL load mask from data_i in enabled byte lanes only.
REQ-022 A FORCE write SHALL OR data_i into stat in enabled lanes (software-raised interrupt).
REQ-023 Bits at or above NUM_SRC SHALL ignore writes and read 0.
REQ-024 irq_o SHALL equal the registered |(stat & mask): one cycle after stat/mask update, two cycles after the irq_i edge.
REQ-025 wen with ben=2'b00 SHALL change no state.

Reset
REQ-026 rst SHALL asynchronously clear stat, mask, prev, irq_o, vec_o and vec_valid_o to 0.
REQ-027 Because prev resets to 0, a source already high at reset release SHALL register as an edge in the first active cycle.
REQ-028 rst asserted mid-operation SHALL discard pending events; no state survives.

Configuration
REQ-029 With PSX_IRQ_VEC_EN defined:
- vec_o SHALL be the registered lowest index n with stat[n]&mask[n], same timing as irq_o.
- vec_valid_o SHALL equal irq_o.
REQ-030 Without PSX_IRQ_VEC_EN, vec_o SHALL be 4'd0 and vec_valid_o SHALL be 0 constantly, and no encoder logic SHALL be built.

Verification
REQ-031 Default params, mask=0x001; pulse irq_i[0] for one cycle at cycle T -> stat_o=0x001 at T+1, irq_o=1 at T+2.
REQ-032 stat=0x009; STAT write data=0xFFF7, ben=01 -> stat_o=0x001; with mask=0x008, irq_o drops one cycle later.
REQ-033 Edge on irq_i[3] in the same cycle as STAT write data=0xFFF7 -> stat_o[3] remains 1.
REQ-034 LEVEL_MASK=0x004, irq_i[2] held high; STAT write data=0xFFFB -> stat_o[2] stays 1; after irq_i[2] falls, the same write clears it.
REQ-035 MASK write data=0x0700, ben=10 -> mask_o=0x700; FORCE write data=0x0500, ben=10 -> stat_o=0x500, irq_o=1, vec_o=8 (VEC_EN defined) or 0 (undefined).
REQ-036 irq_i[1] held high through reset release -> stat_o[1]=1 one cycle after release; rst pulse while stat=0x7FF -> all outputs 0 immediately.

Source files
------------

// File: rtl/psx_irq_ctrl.sv
// psx_irq_ctrl: interrupt status/mask controller for a PSX-style system bus.
//
// Each of NUM_SRC request lines is either edge- or level-sensitive, selected
// per bit by LEVEL_MASK. Events latch into STAT. STAT is cleared by writing 0
// and set by software via FORCE. MASK gates STAT into a registered CPU
// interrupt request.
//
// Optional feature: define PSX_IRQ_VEC_EN to build a registered lowest-index
// vector encoder driving vec_o / vec_valid_o. Without it both outputs are tied
// to zero and no encoder is built.
module psx_irq_ctrl #(
    parameter int          NUM_SRC    = 11,
    parameter logic [15:0] LEVEL_MASK = 16'h0000
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_i,
    input  logic               wen,
    input  logic [1:0]         ben,
    input  logic [1:0]         addr,
    input  logic [15:0]        data_i,
    output logic [31:0]        stat_o,
    output logic [31:0]        mask_o,
    output logic               irq_o,
    output logic [3:0]         vec_o,
    output logic               vec_valid_o
);

    localparam logic [1:0] ADDR_STAT  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_FORCE = 2'd2;

    // Registered state
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] stat_q;
    logic [NUM_SRC-1:0] mask_q;
    logic               irq_q;

    // Next-state and decode
    logic [NUM_SRC-1:0] stat_d;
    logic [NUM_SRC-1:0] mask_d;
    logic               irq_d;
    logic [NUM_SRC-1:0] set_vec;
    logic [NUM_SRC-1:0] pending;
    logic [15:0]        lane_en16;
    logic [NUM_SRC-1:0] lane_en;
    logic [NUM_SRC-1:0] data_src;
    logic [NUM_SRC-1:0] clr_keep;
    logic [NUM_SRC-1:0] force_bits;
    logic               stat_wr;
    logic               mask_wr;
    logic               force_wr;

    // Bits above NUM_SRC have no storage, so the upper data/lane bits are
    // intentionally dropped; fold them here so they are not flagged as unused.
    logic               unused_hi;

    // Byte lanes expand to a per-bit enable; only the implemented bits matter.
    assign lane_en16 = {{8{ben[1]}}, {8{ben[0]}}};
    assign lane_en   = lane_en16[NUM_SRC-1:0];
    assign data_src  = data_i[NUM_SRC-1:0];
    assign unused_hi = ^{data_i, lane_en16};

    // Reserved address 3 decodes to nothing, so writes there are dropped.
    assign stat_wr  = wen && (addr == ADDR_STAT);
    assign mask_wr  = wen && (addr == ADDR_MASK);
    assign force_wr = wen && (addr == ADDR_FORCE);

    // Per-source set condition: level sources set every cycle they are high,
    // edge sources only on a rising transition versus the previous sample.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            if (LEVEL_MASK[gi]) begin : g_level
                assign set_vec[gi] = irq_i[gi];
            end else begin : g_edge
                assign set_vec[gi] = irq_i[gi] & ~prev_q[gi];
            end
        end
    endgenerate

    // Write-0-to-clear only acts on enabled lanes; disabled lanes keep all ones.
    assign clr_keep   = stat_wr  ? (data_src | ~lane_en) : {NUM_SRC{1'b1}};
    assign force_bits = force_wr ? (data_src & lane_en)  : {NUM_SRC{1'b0}};

    // Hardware sets are OR-ed in after the clear so a coincident event wins.
    assign stat_d = (stat_q & clr_keep) | force_bits | set_vec;

    // Mask loads only the enabled lanes and holds the rest.
    assign mask_d = mask_wr ? ((mask_q & ~lane_en) | (data_src & lane_en)) : mask_q;

    // The interrupt request is computed from the already-registered state,
    // giving one cycle of latency after STAT/MASK change.
    assign pending = stat_q & mask_q;
    assign irq_d   = |pending;

    // Core state: input history, status, mask and interrupt request.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            stat_q <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            prev_q <= irq_i;
            stat_q <= stat_d;
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign stat_o = {{(32 - NUM_SRC){1'b0}}, stat_q};
    assign mask_o = {{(32 - NUM_SRC){1'b0}}, mask_q};
    assign irq_o  = irq_q;

`ifdef PSX_IRQ_VEC_EN
    logic [3:0] vec_q;
    logic [3:0] vec_d;

    // Lowest-index priority encoder: scan downward so the lowest hit is last.
    always_comb begin
        vec_d = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                vec_d = 4'(i);
            end
        end
    end

    // Vector is registered alongside irq_q so both refer to the same cycle.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            vec_q <= 4'd0;
        end else begin
            vec_q <= vec_d;
        end
    end

    assign vec_o       = vec_q;
    assign vec_valid_o = irq_q;
`else
    assign vec_o       = 4'd0;
    assign vec_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_psx_irq_ctrl.sv
// Self-checking bench for psx_irq_ctrl (NUM_SRC=11, source 2 level-sensitive).
// Honours PSX_IRQ_VEC_EN for the expected vector outputs.
module tb_psx_irq_ctrl;

    localparam int          NUM   = 11;
    localparam logic [15:0] LEVEL = 16'h0004;

    logic            sys_clk = 1'b0;
    logic            rst     = 1'b1;
    logic [NUM-1:0]  irq_i   = '0;
    logic            wen     = 1'b0;
    logic [1:0]      ben     = 2'b00;
    logic [1:0]      addr    = 2'd0;
    logic [15:0]     data_i  = 16'h0000;
    logic [31:0]     stat_o;
    logic [31:0]     mask_o;
    logic            irq_o;
    logic [3:0]      vec_o;
    logic            vec_valid_o;

    int total = 0;
    int bad   = 0;

    // Reference model state (16-bit wide, bits >= NUM kept at zero)
    logic [15:0] m_stat, m_mask, m_prev;
    logic        m_irq;
    int          m_vec;

    psx_irq_ctrl #(.NUM_SRC(NUM), .LEVEL_MASK(LEVEL)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .irq_i      (irq_i),
        .wen        (wen),
        .ben        (ben),
        .addr       (addr),
        .data_i     (data_i),
        .stat_o     (stat_o),
        .mask_o     (mask_o),
        .irq_o      (irq_o),
        .vec_o      (vec_o),
        .vec_valid_o(vec_valid_o)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [3:0] exp_vec();
`ifdef PSX_IRQ_VEC_EN
        return 4'(m_vec);
`else
        return 4'd0;
`endif
    endfunction

    function automatic logic exp_valid();
`ifdef PSX_IRQ_VEC_EN
        return m_irq;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_stat = '0; m_mask = '0; m_prev = '0; m_irq = 1'b0; m_vec = 0;
    endtask

    // Advance one clock: evaluate the model on the current inputs, then let
    // the DUT clock and settle.
    task automatic step();
        logic [15:0] valid, lane, data, pend, nstat, nmask;
        valid = 16'((32'd1 << NUM) - 1);
        lane  = {ben[1] ? 8'hFF : 8'h00, ben[0] ? 8'hFF : 8'h00};
        data  = data_i;
        pend  = m_stat & m_mask;
        nstat = m_stat;
        nmask = m_mask;
        if (wen && addr == 2'd0) begin
            for (int b = 0; b < 16; b++)
                if (lane[b] && !data[b]) nstat[b] = 1'b0;
        end
        if (wen && addr == 2'd2) nstat = nstat | (data & lane);
        if (wen && addr == 2'd1) begin
            for (int b = 0; b < 16; b++)
                if (lane[b]) nmask[b] = data[b];
        end
        for (int n = 0; n < NUM; n++) begin
            if (LEVEL[n] ? irq_i[n] : (irq_i[n] && !m_prev[n])) nstat[n] = 1'b1;
        end
        m_irq = (pend != 0);
        m_vec = 0;
        for (int n = NUM - 1; n >= 0; n--) if (pend[n]) m_vec = n;
        m_stat = nstat & valid;
        m_mask = nmask & valid;
        m_prev = 16'(irq_i);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [1:0] be, input logic [15:0] d);
        wen = 1'b1; addr = a; ben = be; data_i = d;
        step();
        wen = 1'b0; ben = 2'b00; data_i = 16'h0000;
    endtask

    task automatic test_reset();
        model_reset();
        irq_i = 11'h002;           // held high through reset release
        #3;
        total++; if (stat_o !== 32'h0) begin bad++; $display("FAIL reset_stat: got %h want %h", stat_o, 32'h0); end
        total++; if (mask_o !== 32'h0) begin bad++; $display("FAIL reset_mask: got %h want %h", mask_o, 32'h0); end
        total++; if ({irq_o, vec_valid_o, vec_o} !== 6'h0) begin bad++; $display("FAIL reset_irq_vec: got %b%b%h want 0", irq_o, vec_valid_o, vec_o); end
        @(posedge sys_clk); #1;
        rst = 1'b0;
        step();
        total++; if (stat_o !== 32'h002) begin bad++; $display("FAIL release_edge: got %h want %h", stat_o, 32'h002); end
        step();
        total++; if (stat_o !== 32'h002) begin bad++; $display("FAIL held_no_reedge: got %h want %h", stat_o, 32'h002); end
        $display("test_reset: stat=%h", stat_o);
    endtask

    task automatic test_basic();
        irq_i = '0;
        step();
        do_write(2'd1, 2'b11, 16'h0001);
        do_write(2'd0, 2'b11, 16'h0000);
        irq_i[0] = 1'b1;
        step();
        irq_i[0] = 1'b0;
        total++; if (stat_o !== 32'h001 || irq_o !== 1'b0) begin bad++; $display("FAIL basic_T1: got stat=%h irq=%b want stat=001 irq=0", stat_o, irq_o); end
        step();
        total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL basic_T2: got irq=%b want 1", irq_o); end
        total++; if (vec_o !== exp_vec() || vec_valid_o !== exp_valid()) begin bad++; $display("FAIL basic_vec: got %h/%b want %h/%b", vec_o, vec_valid_o, exp_vec(), exp_valid()); end
        $display("test_basic: stat=%h irq=%b", stat_o, irq_o);
    endtask

    task automatic test_clear();
        do_write(2'd0, 2'b11, 16'h0000);
        do_write(2'd2, 2'b11, 16'h0009);
        do_write(2'd1, 2'b11, 16'h0008);
        step();
        total++; if (stat_o !== 32'h009 || irq_o !== 1'b1) begin bad++; $display("FAIL clear_pre: got stat=%h irq=%b want 009/1", stat_o, irq_o); end
        do_write(2'd0, 2'b01, 16'hFFF7);
        total++; if (stat_o !== 32'h001 || irq_o !== 1'b1) begin bad++; $display("FAIL clear_stat: got stat=%h irq=%b want 001/1", stat_o, irq_o); end
        step();
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL clear_irq_drop: got %b want 0", irq_o); end
        $display("test_clear: stat=%h irq=%b", stat_o, irq_o);
    endtask

    task automatic test_set_priority();
        irq_i[3] = 1'b1;
        do_write(2'd0, 2'b11, 16'hFFF7);
        irq_i[3] = 1'b0;
        total++; if (stat_o[3] !== 1'b1) begin bad++; $display("FAIL set_priority: got stat=%h want bit3=1", stat_o); end
        $display("test_set_priority: stat=%h", stat_o);
    endtask

    task automatic test_level();
        do_write(2'd0, 2'b11, 16'h0000);
        irq_i[2] = 1'b1;
        step();
        step();
        do_write(2'd0, 2'b11, 16'hFFFB);
        total++; if (stat_o[2] !== 1'b1) begin bad++; $display("FAIL level_hold: got stat=%h want bit2=1", stat_o); end
        irq_i[2] = 1'b0;
        step();
        do_write(2'd0, 2'b11, 16'hFFFB);
        total++; if (stat_o[2] !== 1'b0) begin bad++; $display("FAIL level_clear: got stat=%h want bit2=0", stat_o); end
        $display("test_level: stat=%h", stat_o);
    endtask

    task automatic test_force_vec();
        do_write(2'd0, 2'b11, 16'h0000);
        do_write(2'd1, 2'b11, 16'h0000);
        do_write(2'd1, 2'b10, 16'h0700);
        total++; if (mask_o !== 32'h700) begin bad++; $display("FAIL force_mask: got %h want %h", mask_o, 32'h700); end
        do_write(2'd2, 2'b10, 16'h0500);
        total++; if (stat_o !== 32'h500) begin bad++; $display("FAIL force_stat: got %h want %h", stat_o, 32'h500); end
        step();
`ifdef PSX_IRQ_VEC_EN
        total++; if (irq_o !== 1'b1 || vec_o !== 4'd8 || vec_valid_o !== 1'b1) begin bad++; $display("FAIL force_vec: got irq=%b vec=%0d v=%b want 1/8/1", irq_o, vec_o, vec_valid_o); end
`else
        total++; if (irq_o !== 1'b1 || vec_o !== 4'd0 || vec_valid_o !== 1'b0) begin bad++; $display("FAIL force_vec: got irq=%b vec=%0d v=%b want 1/0/0", irq_o, vec_o, vec_valid_o); end
`endif
        $display("test_force_vec: irq=%b vec=%0d", irq_o, vec_o);
    endtask

    task automatic test_no_effect();
        logic [31:0] s0, m0;
        s0 = stat_o; m0 = mask_o;
        do_write(2'd0, 2'b00, 16'h0000);
        do_write(2'd1, 2'b00, 16'hFFFF);
        do_write(2'd2, 2'b00, 16'hFFFF);
        do_write(2'd3, 2'b11, 16'h0000);
        total++; if (stat_o !== s0 || mask_o !== m0) begin bad++; $display("FAIL no_effect: got %h/%h want %h/%h", stat_o, mask_o, s0, m0); end
        do_write(2'd2, 2'b11, 16'hFFFF);
        do_write(2'd1, 2'b11, 16'hFFFF);
        total++; if (stat_o !== 32'h7FF || mask_o !== 32'h7FF) begin bad++; $display("FAIL upper_bits: got %h/%h want 7ff/7ff", stat_o, mask_o); end
        $display("test_no_effect: stat=%h mask=%h", stat_o, mask_o);
    endtask

    task automatic test_async_reset();
        step();
        total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL pre_reset_irq: got %b want 1", irq_o); end
        #2 rst = 1'b1;
        #1;
        model_reset();
        total++; if (stat_o !== 32'h0 || mask_o !== 32'h0 || irq_o !== 1'b0 || vec_o !== 4'd0 || vec_valid_o !== 1'b0)
            begin bad++; $display("FAIL async_reset: got %h/%h/%b/%h/%b want all 0", stat_o, mask_o, irq_o, vec_o, vec_valid_o); end
        irq_i = '0;
        @(posedge sys_clk); #1;
        rst = 1'b0;
        step();
        $display("test_async_reset: stat=%h irq=%b", stat_o, irq_o);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            irq_i  = NUM'($urandom);
            wen    = ($urandom_range(0, 2) == 0);
            addr   = 2'($urandom);
            ben    = 2'($urandom);
            data_i = 16'($urandom);
            step();
            total++; if (stat_o !== {16'h0, m_stat}) begin bad++; $display("FAIL rnd_stat c=%0d: got %h want %h", c, stat_o, m_stat); end
            total++; if (mask_o !== {16'h0, m_mask}) begin bad++; $display("FAIL rnd_mask c=%0d: got %h want %h", c, mask_o, m_mask); end
            total++; if (irq_o !== m_irq) begin bad++; $display("FAIL rnd_irq c=%0d: got %b want %b", c, irq_o, m_irq); end
            total++; if (vec_o !== exp_vec() || vec_valid_o !== exp_valid()) begin bad++; $display("FAIL rnd_vec c=%0d: got %h/%b want %h/%b", c, vec_o, vec_valid_o, exp_vec(), exp_valid()); end
            $display("rnd c=%0d wen=%b a=%0d ben=%b d=%h irq_i=%h stat=%h mask=%h irq=%b", c, wen, addr, ben, data_i, irq_i, stat_o, mask_o, irq_o);
        end
        wen = 1'b0; ben = 2'b00; irq_i = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clear();
        test_set_priority();
        test_level();
        test_force_vec();
        test_no_effect();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
